// File: rtl/sdram_apb_arbiter.sv
// sdram_apb_arbiter: two-port APB arbiter serialising upstream transfers onto the SDRAM APB slave port
// Ports: clock/reset (async active-low); in0_*/in1_* upstream APB slave ports;
// out_* downstream APB master port. Macro SDRAM_ARB_RR_EN selects round-robin, else in0 has fixed priority.
module sdram_apb_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     in0_paddr,
  input  logic                  in0_psel,
  input  logic                  in0_penable,
  input  logic                  in0_pwrite,
  input  logic [2:0]            in0_pprot,
  input  logic [DATA_W-1:0]     in0_pwdata,
  input  logic [DATA_W/8-1:0]   in0_pstrb,
  output logic                  in0_pready,
  output logic [DATA_W-1:0]     in0_prdata,
  output logic                  in0_pslverr,
  input  logic [ADDR_W-1:0]     in1_paddr,
  input  logic                  in1_psel,
  input  logic                  in1_penable,
  input  logic                  in1_pwrite,
  input  logic [2:0]            in1_pprot,
  input  logic [DATA_W-1:0]     in1_pwdata,
  input  logic [DATA_W/8-1:0]   in1_pstrb,
  output logic                  in1_pready,
  output logic [DATA_W-1:0]     in1_prdata,
  output logic                  in1_pslverr,
  output logic [ADDR_W-1:0]     out_paddr,
  output logic                  out_psel,
  output logic                  out_penable,
  output logic [2:0]            out_pprot,
  output logic                  out_pwrite,
  output logic [DATA_W-1:0]     out_pwdata,
  output logic [DATA_W/8-1:0]   out_pstrb,
  input  logic                  out_pready,
  input  logic [DATA_W-1:0]     out_prdata,
  input  logic                  out_pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic grant, win, req, wr, done, unused_penable;
  assign req = in0_psel | in1_psel;
  assign wr = win ? in1_pwrite : in0_pwrite;
  assign unused_penable = in0_penable ^ in1_penable;
`ifdef SDRAM_ARB_RR_EN
  logic last;
  // on a contest the port that was not served last wins
  assign win = (in0_psel & in1_psel) ? ~last : in1_psel;
  always_ff @(posedge clock or negedge reset)
    if (!reset) last <= 1'b1;
    else if (state == IDLE && req) last <= win;
`else
  assign win = ~in0_psel;
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= 1'b0;
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      out_paddr   <= '0;
      out_pprot   <= '0;
      out_pwrite  <= 1'b0;
      out_pwdata  <= '0;
      out_pstrb   <= '0;
    end else if (state == IDLE) begin
      if (req) begin
        state      <= SETUP;
        grant      <= win;
        out_psel   <= 1'b1;
        out_paddr  <= win ? in1_paddr : in0_paddr;
        out_pprot  <= win ? in1_pprot : in0_pprot;
        out_pwrite <= wr;
        out_pwdata <= wr ? (win ? in1_pwdata : in0_pwdata) : '0;
        out_pstrb  <= wr ? (win ? in1_pstrb : in0_pstrb) : '0;
      end
    end else if (state == SETUP) begin
      state       <= ACCESS;
      out_penable <= 1'b1;
    end else if (out_pready) begin
      state       <= IDLE;
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
    end
  end
  // a requester that dropped psel mid-transfer gets no response
  assign done        = state == ACCESS && out_pready;
  assign in0_pready  = done & ~grant & in0_psel;
  assign in1_pready  = done & grant & in1_psel;
  assign in0_prdata  = (state == ACCESS && !grant) ? out_prdata : '0;
  assign in1_prdata  = (state == ACCESS && grant) ? out_prdata : '0;
  assign in0_pslverr = in0_pready & out_pslverr;
  assign in1_pslverr = in1_pready & out_pslverr;
endmodule

// File: tb/tb_sdram_apb_arbiter.sv
// tb_sdram_apb_arbiter: self-checking bench with a transaction-level model of the arbiter
module tb_sdram_apb_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  logic [31:0] paddr_a [2];
  logic [31:0] pwdata_a [2];
  logic        psel_a [2];
  logic        pwrite_a [2];
  logic [2:0]  pprot_a [2];
  logic [3:0]  pstrb_a [2];
  logic        in0_pready, in1_pready, in0_pslverr, in1_pslverr;
  logic [31:0] in0_prdata, in1_prdata;
  logic [31:0] out_paddr, out_pwdata;
  logic        out_psel, out_penable, out_pwrite;
  logic [2:0]  out_pprot;
  logic [3:0]  out_pstrb;
  logic        out_pready = 1'b0;
  logic [31:0] out_prdata = '0;
  logic        out_pslverr = 1'b0;
  sdram_apb_arbiter dut (
    .clock(clock), .reset(reset),
    .in0_paddr(paddr_a[0]), .in0_psel(psel_a[0]), .in0_penable(1'b0), .in0_pwrite(pwrite_a[0]),
    .in0_pprot(pprot_a[0]), .in0_pwdata(pwdata_a[0]), .in0_pstrb(pstrb_a[0]),
    .in0_pready(in0_pready), .in0_prdata(in0_prdata), .in0_pslverr(in0_pslverr),
    .in1_paddr(paddr_a[1]), .in1_psel(psel_a[1]), .in1_penable(1'b0), .in1_pwrite(pwrite_a[1]),
    .in1_pprot(pprot_a[1]), .in1_pwdata(pwdata_a[1]), .in1_pstrb(pstrb_a[1]),
    .in1_pready(in1_pready), .in1_prdata(in1_prdata), .in1_pslverr(in1_pslverr),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable), .out_pprot(out_pprot),
    .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
    .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
  );
  int total = 0;
  int bad = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask
  int wait_n = 0;
  int scnt = 0;
  always @(posedge clock) begin
    #1;
    if (!out_penable) begin
      scnt = 0;
      out_pready = 1'b0;
    end else begin
      out_pready = scnt >= wait_n;
      scnt++;
    end
  end
  bit m_act = 0;
  int m_cyc = 0;
  int m_g = 0;
  int m_last = 1;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_strb;
  logic [2:0]  m_prot;
  logic        m_wr;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_act = 0;
      m_last = 1;
    end else if (m_act) begin
      if (m_cyc >= 2 && out_pready) m_act = 0;
      else m_cyc++;
    end else if (psel_a[0] || psel_a[1]) begin
`ifdef SDRAM_ARB_RR_EN
      if (psel_a[0] && psel_a[1]) m_g = (m_last == 0) ? 1 : 0;
      else m_g = psel_a[1] ? 1 : 0;
`else
      m_g = psel_a[0] ? 0 : 1;
`endif
      m_last = m_g;
      m_act = 1;
      m_cyc = 1;
      m_addr = paddr_a[m_g];
      m_prot = pprot_a[m_g];
      m_wr = pwrite_a[m_g];
      m_wdata = m_wr ? pwdata_a[m_g] : 32'h0;
      m_strb = m_wr ? pstrb_a[m_g] : 4'h0;
    end
  end
  int cnt_rdy [2];
  int cnt_err [2];
  int pen_cnt = 0;
  bit seen [2];
  logic [31:0] rdata_seen [2];
  logic [31:0] wdata_or;
  logic [3:0]  strb_or;
  always @(negedge clock) begin
    bit acc, done;
    acc = m_act && m_cyc >= 2;
    done = acc && out_pready;
    chk("psel", out_psel, m_act);
    chk("penable", out_penable, acc);
    if (m_act) begin
      chk("paddr", out_paddr, m_addr);
      chk("pprot", out_pprot, m_prot);
      chk("pwrite", out_pwrite, m_wr);
      chk("pwdata", out_pwdata, m_wdata);
      chk("pstrb", out_pstrb, m_strb);
      chk(m_g ? "in0_prdata_idle" : "in1_prdata_idle", m_g ? in0_prdata : in1_prdata, 0);
      if (done) chk("prdata_granted", m_g ? in1_prdata : in0_prdata, out_prdata);
    end
    if (!reset) begin
      chk("rst_in0_prdata", in0_prdata, 0);
      chk("rst_in1_prdata", in1_prdata, 0);
    end
    chk("in0_pready", in0_pready, done && m_g == 0);
    chk("in1_pready", in1_pready, done && m_g == 1);
    chk("in0_pslverr", in0_pslverr, done && m_g == 0 && out_pslverr);
    chk("in1_pslverr", in1_pslverr, done && m_g == 1 && out_pslverr);
    if (in0_pready) begin cnt_rdy[0]++; seen[0] = 1; rdata_seen[0] = in0_prdata; end
    if (in1_pready) begin cnt_rdy[1]++; seen[1] = 1; rdata_seen[1] = in1_prdata; end
    if (in0_pslverr) cnt_err[0]++;
    if (in1_pslverr) cnt_err[1]++;
    if (out_penable) pen_cnt++;
    if (out_psel) begin wdata_or |= out_pwdata; strb_or |= out_pstrb; end
  end
  int left [2];
  int glog [$];
  always @(posedge clock) begin
    #1;
    for (int p = 0; p < 2; p++)
      if (seen[p]) begin
        seen[p] = 0;
        glog.push_back(p);
        if (left[p] > 0) left[p]--;
        psel_a[p] = left[p] > 0;
        paddr_a[p] += 4;
        pwdata_a[p] += 1;
      end
  end
  task automatic clr();
    for (int p = 0; p < 2; p++) begin cnt_rdy[p] = 0; cnt_err[p] = 0; end
    pen_cnt = 0;
    wdata_or = '0;
    strb_or = '0;
    glog.delete();
  endtask
  task automatic setup(input int p, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] pr, input int n);
    paddr_a[p] = a; pwrite_a[p] = w; pwdata_a[p] = d; pstrb_a[p] = s; pprot_a[p] = pr;
    left[p] = n;
    psel_a[p] = n > 0;
  endtask
  task automatic wait_done(input int maxc);
    int n = 0;
    while ((left[0] > 0 || left[1] > 0 || out_psel) && n < maxc) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n >= maxc) begin
      bad++;
      $display("FAIL wait_done timeout after %0d cycles, required completion", n);
    end
    @(negedge clock);
  endtask
  initial begin
    for (int p = 0; p < 2; p++) begin
      setup(p, 0, 0, 0, 0, 0, 0);
      seen[p] = 0;
      left[p] = 0;
      rdata_seen[p] = 0;
    end
    clr();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_paddr", out_paddr, 0);
    chk("rst_pwdata", out_pwdata, 0);
    chk("rst_pstrb", out_pstrb, 0);
    chk("rst_pwrite", out_pwrite, 0);
    chk("rst_pprot", out_pprot, 0);
    @(posedge clock); #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    // single write on in0 with 4 wait states
    #2 clr();
    wait_n = 4;
    setup(0, 32'hA000_0010, 1, 32'hDEADBEEF, 4'hF, 3'b010, 1);
    @(negedge clock);
    chk("lat_T_psel", out_psel, 0);
    @(negedge clock);
    chk("lat_T1_psel", out_psel, 1);
    chk("lat_T1_penable", out_penable, 0);
    chk("lat_T1_paddr", out_paddr, 32'hA000_0010);
    @(negedge clock);
    chk("lat_T2_penable", out_penable, 1);
    wait_done(50);
    chk("w_in0_pulses", cnt_rdy[0], 1);
    chk("w_in1_pulses", cnt_rdy[1], 0);
    chk("w_access_cycles", pen_cnt, 5);
    // read on in1: response routed to in1 only, strobes and data suppressed downstream
    @(posedge clock); #2 clr();
    wait_n = 1;
    out_prdata = 32'h1234_5678;
    setup(1, 32'h0000_0200, 0, 32'h5555_AAAA, 4'hF, 3'b001, 1);
    wait_done(50);
    chk("r_in1_prdata", rdata_seen[1], 32'h1234_5678);
    chk("r_in1_pulses", cnt_rdy[1], 1);
    chk("r_in0_pulses", cnt_rdy[0], 0);
    chk("r_out_pstrb", strb_or, 0);
    chk("r_out_pwdata", wdata_or, 0);
    // both ports requesting continuously
    @(posedge clock); #2 clr();
    wait_n = 0;
    out_prdata = 32'hCAFE_0000;
`ifdef SDRAM_ARB_RR_EN
    setup(0, 32'h0000_1000, 1, 32'h0000_0100, 4'h3, 3'b000, 4);
    setup(1, 32'h0000_2000, 1, 32'h0000_0200, 4'hC, 3'b100, 4);
`else
    setup(0, 32'h0000_1000, 1, 32'h0000_0100, 4'h3, 3'b000, 8);
    setup(1, 32'h0000_2000, 1, 32'h0000_0200, 4'hC, 3'b100, 1);
`endif
    wait_done(200);
    for (int i = 0; i < 8; i++) begin
`ifdef SDRAM_ARB_RR_EN
      chk($sformatf("grant_%0d", i), (i < glog.size()) ? glog[i] : -1, i % 2);
`else
      chk($sformatf("grant_%0d", i), (i < glog.size()) ? glog[i] : -1, 0);
`endif
    end
`ifndef SDRAM_ARB_RR_EN
    chk("grant_8", (glog.size() > 8) ? glog[8] : -1, 1);
`endif
    // error response on an in0 read
    @(posedge clock); #2 clr();
    wait_n = 2;
    out_pslverr = 1'b1;
    setup(0, 32'h0000_3000, 0, 32'h0, 4'hF, 3'b000, 1);
    wait_done(50);
    out_pslverr = 1'b0;
    chk("e_in0_err_pulses", cnt_err[0], 1);
    chk("e_in1_err_pulses", cnt_err[1], 0);
    // reset asserted in ACCESS aborts; pending in1 re-arbitrated after release
    @(posedge clock); #2 clr();
    wait_n = 10;
    setup(1, 32'h0000_4000, 1, 32'h0000_0444, 4'h5, 3'b011, 1);
    for (int i = 0; i < 20 && !out_penable; i++) @(negedge clock);
    chk("rr_in_access", out_penable, 1);
    @(posedge clock); #3 reset = 1'b0;
    #1;
    chk("rst_mid_psel", out_psel, 0);
    chk("rst_mid_penable", out_penable, 0);
    chk("rst_mid_in1_pready", in1_pready, 0);
    @(posedge clock); #2 reset = 1'b1;
    wait_n = 0;
    wait_done(50);
    chk("rst_in1_pulses", cnt_rdy[1], 1);
    chk("rst_glog_size", glog.size(), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired, required bench completion");
    $fatal(1, "watchdog");
  end
endmodule
